// File: rtl/vga_pixel_sink_pkg.sv
// rtl/vga_pixel_sink_pkg.sv - shared constants, controller states and framebuffer addressing
package vga_pixel_sink_pkg;

    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int FB_DEPTH = 19200;
    localparam int FB_AW    = 15;

    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_TOTAL = 800;

    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_TOTAL = 525;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ctrl_state_t;

    // row*160 + col built from two shifts so no multiplier is inferred
    function automatic logic [FB_AW-1:0] fb_addr(input logic [7:0] col, input logic [6:0] row);
        return {1'b0, row, 7'd0} + {3'd0, row, 5'd0} + {7'd0, col};
    endfunction

endpackage

// File: rtl/fb_ram_dp.sv
// rtl/fb_ram_dp.sv - simple dual-port framebuffer RAM, registered read returns pre-write data
module fb_ram_dp #(
    parameter int DW    = 3,
    parameter int DEPTH = 19200,
    parameter int AW    = 15
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/vga_pixel_sink.sv
// rtl/vga_pixel_sink.sv - 160x120x3 framebuffer with clear engine and 640x480 VGA scan-out
module vga_pixel_sink
    import vga_pixel_sink_pkg::*;
#(
    parameter logic [2:0] BG_COLOUR      = 3'b000,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       plot,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    output logic       busy,
    output logic       drop_flag,
    output logic       frame_start,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [9:0] VGA_R,
    output logic [9:0] VGA_G,
    output logic [9:0] VGA_B
);

    localparam ctrl_state_t     RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;
    localparam logic [FB_AW-1:0] CLR_LAST   = FB_AW'(FB_DEPTH - 1);
    localparam logic [7:0]      X_LIM       = 8'(FB_W);
    localparam logic [6:0]      Y_LIM       = 7'(FB_H);
    localparam logic [9:0]      H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0]      V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0]      H_VIS_L     = 10'(H_VIS);
    localparam logic [9:0]      V_VIS_L     = 10'(V_VIS);
    localparam logic [9:0]      HS_BEG      = 10'(H_VIS + H_FP);
    localparam logic [9:0]      HS_END      = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]      VS_BEG      = 10'(V_VIS + V_FP);
    localparam logic [9:0]      VS_END      = 10'(V_VIS + V_FP + V_SYNC);

    ctrl_state_t      state;
    ctrl_state_t      state_nxt;
    logic [FB_AW-1:0] clr_addr;
    logic [FB_AW-1:0] clr_addr_nxt;
    logic             clr_we;

    logic             plot_ok;
    logic             wr_en;
    logic [FB_AW-1:0] wr_addr;
    logic [2:0]       wr_data;

    logic             pix_en;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             scan_vis;
    logic             scan_hs;
    logic             scan_vs;
    logic [FB_AW-1:0] rd_addr;
    logic [2:0]       rd_data;

    logic             s1_vis;
    logic             s1_hs;
    logic             s1_vs;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= RESET_STATE;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        busy         = 1'b0;
        clr_we       = 1'b0;
        case (state)
            CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (clr_addr == CLR_LAST) begin
                    state_nxt    = RUN;
                    clr_addr_nxt = '0;
                end else begin
                    clr_addr_nxt = clr_addr + 1'b1;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // The clear engine owns the write port outright; user plots only land in RUN
    assign plot_ok = plot && !busy && (x < X_LIM) && (y < Y_LIM);
    assign wr_en   = clr_we || plot_ok;
    assign wr_addr = clr_we ? clr_addr : fb_addr(x, y);
    assign wr_data = clr_we ? BG_COLOUR : colour;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_flag <= 1'b0;
        end else if (plot && !plot_ok) begin
            drop_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_en <= 1'b0;
            h_cnt  <= '0;
            v_cnt  <= '0;
        end else begin
            pix_en <= ~pix_en;
            if (pix_en) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    // Pulse on the first of the two clks spent at the origin
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= (h_cnt == '0) && (v_cnt == '0) && !pix_en;
        end
    end

    assign scan_vis = (h_cnt < H_VIS_L) && (v_cnt < V_VIS_L);
    assign scan_hs  = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    assign scan_vs  = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    // Blanked positions read address 0 so the read never leaves the array
    assign rd_addr  = scan_vis ? fb_addr(h_cnt[9:2], v_cnt[8:2]) : '0;

    fb_ram_dp #(
        .DW    (3),
        .DEPTH (FB_DEPTH),
        .AW    (FB_AW)
    ) u_fb (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Stage 1 matches the RAM read latency, stage 2 drives the pins together with colour
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_vis      <= 1'b0;
            s1_hs       <= 1'b1;
            s1_vs       <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else begin
            s1_vis      <= scan_vis;
            s1_hs       <= scan_hs;
            s1_vs       <= scan_vs;
            VGA_BLANK_N <= s1_vis;
            VGA_HS      <= s1_hs;
            VGA_VS      <= s1_vs;
            VGA_R       <= s1_vis ? {10{rd_data[2]}} : 10'd0;
            VGA_G       <= s1_vis ? {10{rd_data[1]}} : 10'd0;
            VGA_B       <= s1_vis ? {10{rd_data[0]}} : 10'd0;
        end
    end

    assign VGA_CLK    = pix_en;
    assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_pixel_sink.sv
// tb/tb_vga_pixel_sink.sv - self-checking bench for vga_pixel_sink against a frame-level model
module tb_vga_pixel_sink;

    localparam logic [2:0] TB_BG = 3'b010;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       plot = 1'b0;
    logic [7:0] x = 8'd0;
    logic [6:0] y = 7'd0;
    logic [2:0] colour = 3'd0;
    logic       busy, drop_flag, frame_start;
    logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
    logic [9:0] VGA_R, VGA_G, VGA_B;

    logic       resetn2 = 1'b0;
    logic       plot2 = 1'b0;
    logic [7:0] x2 = 8'd0;
    logic [6:0] y2 = 7'd0;
    logic [2:0] colour2 = 3'd0;
    logic       busy2, drop2, fs2;
    logic       clk2_o, hs2, vs2, blank2, sync2;
    logic [9:0] r2, g2, b2;

    vga_pixel_sink #(.BG_COLOUR(TB_BG), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .resetn(resetn), .plot(plot), .x(x), .y(y), .colour(colour),
        .busy(busy), .drop_flag(drop_flag), .frame_start(frame_start),
        .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N(VGA_SYNC_N), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    vga_pixel_sink #(.BG_COLOUR(3'b000), .CLEAR_ON_RESET(1'b0)) dut2 (
        .clk(clk), .resetn(resetn2), .plot(plot2), .x(x2), .y(y2), .colour(colour2),
        .busy(busy2), .drop_flag(drop2), .frame_start(fs2),
        .VGA_CLK(clk2_o), .VGA_HS(hs2), .VGA_VS(vs2), .VGA_BLANK_N(blank2),
        .VGA_SYNC_N(sync2), .VGA_R(r2), .VGA_G(g2), .VGA_B(b2)
    );

    always #10 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk1(input string name, input logic act, input logic want);
        vectors++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, want);
        end
    endtask

    task automatic chk10(input string name, input logic [9:0] act, input logic [9:0] want);
        vectors++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic chk32(input string name, input int act, input int want);
        vectors++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    // Model: framebuffer image (bit 3 = content unknown) plus pins expected two clks later
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       blank;
        logic       known;
        logic [2:0] col;
    } pin_t;

    localparam pin_t RST_PIN = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, known: 1'b1, col: 3'd0};

    logic [3:0] mem [19200];
    bit         mem_init = 1'b0;
    int         k = 0;
    pin_t       pipe_a = RST_PIN;
    pin_t       pipe_b = RST_PIN;
    pin_t       cur;
    logic       exp_drop = 1'b0;
    bit         pend_we = 1'b0;
    int         pend_a = 0;
    logic [3:0] pend_d = 4'd0;
    int         fs_count = 0;

    function automatic pin_t scan_entry(input int kk);
        int   p, h, v, a;
        pin_t e;
        p       = kk / 2;
        h       = p % 800;
        v       = (p / 800) % 525;
        e.hs    = !(h >= 656 && h < 752);
        e.vs    = !(v >= 490 && v < 492);
        e.blank = (h < 640) && (v < 480);
        if (e.blank) begin
            a       = (v / 4) * 160 + h / 4;
            e.known = !mem[a][3];
            e.col   = mem[a][2:0];
        end else begin
            e.known = 1'b1;
            e.col   = 3'd0;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 19200; i++) mem[i] = 4'h8;
            mem_init = 1'b1;
        end
        if (!resetn) mem[0] = 4'h8;
        else if (pend_we) mem[pend_a] = pend_d;
    end

    always @(negedge clk) begin
        if (!resetn) begin
            chk1("rst_hs", VGA_HS, 1'b1);
            chk1("rst_vs", VGA_VS, 1'b1);
            chk1("rst_blank_n", VGA_BLANK_N, 1'b0);
            chk1("rst_vga_clk", VGA_CLK, 1'b0);
            chk10("rst_r", VGA_R, 10'd0);
            chk10("rst_g", VGA_G, 10'd0);
            chk10("rst_b", VGA_B, 10'd0);
            chk1("rst_busy", busy, 1'b1);
            chk1("rst_drop", drop_flag, 1'b0);
            chk1("rst_frame_start", frame_start, 1'b0);
            k        = 0;
            pipe_a   = RST_PIN;
            pipe_b   = RST_PIN;
            exp_drop = 1'b0;
            pend_we  = 1'b0;
            fs_count = 0;
        end else begin
            cur = pipe_b;
            chk1("hs", VGA_HS, cur.hs);
            chk1("vs", VGA_VS, cur.vs);
            chk1("blank_n", VGA_BLANK_N, cur.blank);
            if (cur.known) begin
                chk10("r", VGA_R, {10{cur.col[2]}});
                chk10("g", VGA_G, {10{cur.col[1]}});
                chk10("b", VGA_B, {10{cur.col[0]}});
            end
            chk1("sync_n", VGA_SYNC_N, 1'b0);
            chk1("vga_clk", VGA_CLK, (k % 2) == 1);
            chk1("busy", busy, k < 19200);
            chk1("drop", drop_flag, exp_drop);
            chk1("frame_start", frame_start, (k >= 1) && ((k - 1) % 840000 == 0));
            if (frame_start) fs_count++;
            pipe_b = pipe_a;
            pipe_a = scan_entry(k);
            if (plot && (k < 19200 || int'(x) >= 160 || int'(y) >= 120)) exp_drop = 1'b1;
            if (k < 19200) begin
                pend_we = 1'b1;
                pend_a  = k;
                pend_d  = {1'b0, TB_BG};
            end else if (plot && int'(x) < 160 && int'(y) < 120) begin
                pend_we = 1'b1;
                pend_a  = int'(y) * 160 + int'(x);
                pend_d  = {1'b0, colour};
            end else begin
                pend_we = 1'b0;
            end
            k++;
        end
    end

    int cyc = 0;

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic step2();
        @(posedge clk);
        #1;
    endtask

    int hs_low   = 0;
    int blank_hi = 0;

    initial begin
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        cyc = 0;

        goto(100);
        plot = 1'b1; x = 8'd3; y = 7'd3; colour = 3'b111;
        goto(101);
        plot = 1'b0;
        goto(102);
        chk1("drop_after_busy_plot_run1", drop_flag, 1'b1);

        goto(9000);
        resetn = 1'b0;
        #1;
        chk1("midclear_rst_busy", busy, 1'b1);
        chk1("midclear_rst_drop", drop_flag, 1'b0);
        chk1("midclear_rst_hs", VGA_HS, 1'b1);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        cyc = 0;
        chk1("rel_vga_clk0", VGA_CLK, 1'b0);
        chk1("rel_busy", busy, 1'b1);
        goto(1);
        chk1("vga_clk1", VGA_CLK, 1'b1);
        chk1("frame_start_c1", frame_start, 1'b1);
        goto(2);
        chk1("frame_start_c2", frame_start, 1'b0);

        goto(50);
        plot = 1'b1; x = 8'd10; y = 7'd8; colour = 3'b111;
        goto(51);
        plot = 1'b0;
        goto(52);
        chk1("drop_after_busy_plot", drop_flag, 1'b1);

        goto(19199);
        chk1("busy_last_clear_clk", busy, 1'b1);
        goto(19200);
        chk1("busy_fallen", busy, 1'b0);

        goto(19300);
        plot = 1'b1; x = 8'd5; y = 7'd7; colour = 3'b101;
        goto(19301);
        plot = 1'b0;

        for (int i = 0; i < 1600; i++) begin
            goto(20802 + i);
            if (!VGA_HS) hs_low++;
            if (VGA_BLANK_N) blank_hi++;
            if (cyc == 22081) chk1("blank_last_visible", VGA_BLANK_N, 1'b1);
            if (cyc == 22082) chk1("blank_first_blanked", VGA_BLANK_N, 1'b0);
            if (cyc == 22113) chk1("hs_before_sync", VGA_HS, 1'b1);
            if (cyc == 22114) chk1("hs_first_sync", VGA_HS, 1'b0);
        end
        chk32("hs_low_clks_line13", hs_low, 192);
        chk32("blank_hi_clks_line13", blank_hi, 1280);

        goto(44840);
        chk10("left_neighbour_r", VGA_R, 10'd0);
        chk10("left_neighbour_g", VGA_G, 10'h3FF);
        goto(44842);
        chk10("plot_px_r", VGA_R, 10'h3FF);
        chk10("plot_px_g", VGA_G, 10'd0);
        chk10("plot_px_b", VGA_B, 10'h3FF);
        goto(44850);
        chk10("right_neighbour_r", VGA_R, 10'd0);
        chk10("right_neighbour_g", VGA_G, 10'h3FF);
        goto(49649);
        chk10("plot_px_corner_r", VGA_R, 10'h3FF);
        chk10("plot_px_corner_b", VGA_B, 10'h3FF);
        goto(51242);
        chk10("below_neighbour_g", VGA_G, 10'h3FF);
        chk10("below_neighbour_r", VGA_R, 10'd0);
        goto(51282);
        chk10("busy_target_g", VGA_G, 10'h3FF);
        chk10("busy_target_r", VGA_R, 10'd0);
        chk10("busy_target_b", VGA_B, 10'd0);
        goto(51300);
        chk32("frame_start_count", fs_count, 1);

        chk1("d2_rst_busy", busy2, 1'b0);
        chk1("d2_rst_drop", drop2, 1'b0);
        chk1("d2_rst_hs", hs2, 1'b1);
        chk1("d2_rst_vs", vs2, 1'b1);
        chk1("d2_rst_blank", blank2, 1'b0);
        chk1("d2_rst_fs", fs2, 1'b0);
        @(posedge clk);
        #1 resetn2 = 1'b1;
        plot2 = 1'b1; x2 = 8'd0; y2 = 7'd0; colour2 = 3'b110;
        step2();
        plot2 = 1'b0;
        chk1("d2_busy", busy2, 1'b0);
        chk1("d2_fs", fs2, 1'b1);
        chk1("d2_vga_clk", clk2_o, 1'b1);
        step2();
        chk1("d2_blank_c2", blank2, 1'b1);
        chk1("d2_sync_n", sync2, 1'b0);
        step2();
        chk10("d2_c3_r", r2, 10'h3FF);
        chk10("d2_c3_g", g2, 10'h3FF);
        chk10("d2_c3_b", b2, 10'd0);
        plot2 = 1'b1; colour2 = 3'b001;
        step2();
        plot2 = 1'b0;
        chk10("d2_c4_g", g2, 10'h3FF);
        step2();
        chk10("d2_same_addr_old_r", r2, 10'h3FF);
        chk10("d2_same_addr_old_b", b2, 10'd0);
        chk1("d2_drop_valid", drop2, 1'b0);
        step2();
        chk10("d2_c6_r", r2, 10'd0);
        chk10("d2_c6_b", b2, 10'h3FF);
        plot2 = 1'b1; x2 = 8'd160; y2 = 7'd0;
        step2();
        plot2 = 1'b0;
        chk10("d2_c7_b", b2, 10'h3FF);
        chk1("d2_c7_vs", vs2, 1'b1);
        step2();
        chk1("d2_drop_x160", drop2, 1'b1);
        repeat (10) step2();
        chk1("d2_drop_sticky", drop2, 1'b1);
        resetn2 = 1'b0;
        #1;
        chk1("d2_drop_cleared", drop2, 1'b0);
        step2();
        resetn2 = 1'b1;
        plot2 = 1'b1; x2 = 8'd0; y2 = 7'd120;
        step2();
        plot2 = 1'b0;
        step2();
        chk1("d2_drop_y120", drop2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
